// File: rtl/fetch_decode_stage.sv
// ============================================================================
//  Module   : fetch_decode_stage
//  Brief    : Instruction register, branch/halt decode and loadable offset table
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_decode_stage #(
    parameter int             IW        = 9,
    parameter int             AW        = 8,
    parameter int             LUT_AW    = 5,
    parameter logic [2:0]     BRANCH_OP = 3'b111,
    parameter logic [IW-1:0]  HALT_WORD = 9'h1BF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     pc,
    output logic [AW-1:0]     imem_addr,
    input  logic [IW-1:0]     imem_rdata,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [7:0]        lut_wdata,
    output logic [IW-1:0]     ir,
    output logic              ir_valid,
    output logic              branchsig,
    output logic              branchtype,
    output logic [7:0]        BranchOut,
    output logic              halt
);

    localparam int         c_LUT_DEPTH = 2**LUT_AW;

    localparam logic [1:0] S_FILL   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_BUBBLE = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [IW-1:0] r_ir;
    logic [7:0]    r_table [c_LUT_DEPTH];

    logic          w_valid;
    logic          w_is_branch;
    logic          w_is_halt;

    assign imem_addr   = pc;
    assign w_valid     = (r_state == S_RUN);
    assign w_is_branch = w_valid && (r_ir[IW-1:IW-3] == BRANCH_OP);
    assign w_is_halt   = w_valid && (r_ir == HALT_WORD);

    assign ir          = r_ir;
    assign ir_valid    = w_valid;
    assign branchsig   = w_is_branch;
    assign branchtype  = r_ir[5];
    assign BranchOut   = r_table[r_ir[LUT_AW-1:0]];
    // Combinational so the PC freezes on the very cycle HALT is decoded.
    assign halt        = (r_state == S_HALTED) || w_is_halt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:   w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_is_branch)
                    w_state_nxt = S_BUBBLE;
                else if (w_is_halt)
                    w_state_nxt = S_HALTED;
                else
                    w_state_nxt = S_RUN;
            end
            S_BUBBLE: w_state_nxt = S_RUN;
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FILL;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != S_HALTED)
                r_ir <= imem_rdata;
        end
    end

    // Table writes are honoured in every state, HALTED included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_LUT_DEPTH; i++)
                r_table[i] <= 8'h00;
        end else if (lut_we) begin
            r_table[lut_waddr] <= lut_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_stage.sv
// ============================================================================
//  Module   : tb_fetch_decode_stage
//  Brief    : Directed vector bench for fetch_decode_stage
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_decode_stage;

    typedef struct {
        logic [7:0] pc;
        logic [8:0] rd;
        logic       we;
        logic [4:0] wa;
        logic [7:0] wd;
        logic [8:0] e_ir;
        logic       e_v;
        logic       e_bs;
        logic       e_bt;
        logic [7:0] e_bo;
        logic       e_h;
    } vec_t;

    localparam int NVEC = 21;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pc;
    logic [7:0] imem_addr;
    logic [8:0] imem_rdata;
    logic       lut_we;
    logic [4:0] lut_waddr;
    logic [7:0] lut_wdata;
    logic [8:0] ir;
    logic       ir_valid;
    logic       branchsig;
    logic       branchtype;
    logic [7:0] BranchOut;
    logic       halt;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [NVEC];

    fetch_decode_stage dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .branchsig  (branchsig),
        .branchtype (branchtype),
        .BranchOut  (BranchOut),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] p, input logic [8:0] r,
                                input logic w, input logic [4:0] a, input logic [7:0] d,
                                input logic [8:0] eir, input logic ev, input logic ebs,
                                input logic ebt, input logic [7:0] ebo, input logic eh);
        vec_t v;
        v.pc = p;  v.rd = r;  v.we = w;  v.wa = a;  v.wd = d;
        v.e_ir = eir; v.e_v = ev; v.e_bs = ebs; v.e_bt = ebt; v.e_bo = ebo; v.e_h = eh;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive a vector's inputs, then check the outputs visible before the next edge.
    task automatic apply(input int idx);
        vec_t v;
        v = vecs[idx];
        pc         = v.pc;
        imem_rdata = v.rd;
        lut_we     = v.we;
        lut_waddr  = v.wa;
        lut_wdata  = v.wd;
        #1;
        chk("imem_addr",  idx, 32'(imem_addr),  32'(v.pc));
        chk("ir",         idx, 32'(ir),         32'(v.e_ir));
        chk("ir_valid",   idx, 32'(ir_valid),   32'(v.e_v));
        chk("branchsig",  idx, 32'(branchsig),  32'(v.e_bs));
        chk("branchtype", idx, 32'(branchtype), 32'(v.e_bt));
        chk("BranchOut",  idx, 32'(BranchOut),  32'(v.e_bo));
        chk("halt",       idx, 32'(halt),       32'(v.e_h));
    endtask

    initial begin
        //           pc     rdata   we wa     wd      ir      v  bs bt bo     h
        vecs[0]  = mk(8'd0,   9'h001, 0, 5'd0,  8'h00, 9'h000, 0, 0, 0, 8'h00, 0);
        vecs[1]  = mk(8'd1,   9'h002, 0, 5'd0,  8'h00, 9'h001, 1, 0, 0, 8'h00, 0);
        vecs[2]  = mk(8'd2,   9'h003, 0, 5'd0,  8'h00, 9'h002, 1, 0, 0, 8'h00, 0);
        // table[3] written while the IR decodes index 3: old value this cycle
        vecs[3]  = mk(8'd3,   9'h000, 1, 5'd3,  8'h05, 9'h003, 1, 0, 0, 8'h00, 0);
        vecs[4]  = mk(8'd4,   9'h1C3, 0, 5'd0,  8'h00, 9'h000, 1, 0, 0, 8'h00, 0);
        // blt at pc 4: target 4+1+5 = 10
        vecs[5]  = mk(8'd5,   9'h00A, 0, 5'd0,  8'h00, 9'h1C3, 1, 1, 0, 8'h05, 0);
        vecs[6]  = mk(8'd10,  9'h0AA, 0, 5'd0,  8'h00, 9'h00A, 0, 0, 0, 8'h00, 0);
        vecs[7]  = mk(8'd11,  9'h000, 1, 5'd0,  8'hFD, 9'h0AA, 1, 0, 1, 8'h00, 0);
        vecs[8]  = mk(8'd7,   9'h1E0, 0, 5'd0,  8'h00, 9'h000, 1, 0, 0, 8'hFD, 0);
        // bne at pc 7: target 7+1-3 = 5
        vecs[9]  = mk(8'd8,   9'h011, 0, 5'd0,  8'h00, 9'h1E0, 1, 1, 1, 8'hFD, 0);
        vecs[10] = mk(8'd5,   9'h055, 0, 5'd0,  8'h00, 9'h011, 0, 0, 0, 8'h00, 0);
        vecs[11] = mk(8'd6,   9'h000, 1, 5'd4,  8'h02, 9'h055, 1, 0, 0, 8'h00, 0);
        vecs[12] = mk(8'd255, 9'h1C4, 0, 5'd0,  8'h00, 9'h000, 1, 0, 0, 8'hFD, 0);
        // branch at pc 255, PC already wrapped to 0; wrong-path word is itself a branch
        vecs[13] = mk(8'd0,   9'h1C3, 0, 5'd0,  8'h00, 9'h1C4, 1, 1, 0, 8'h02, 0);
        vecs[14] = mk(8'd2,   9'h077, 0, 5'd0,  8'h00, 9'h1C3, 0, 0, 0, 8'h05, 0);
        vecs[15] = mk(8'd3,   9'h1BF, 0, 5'd0,  8'h00, 9'h077, 1, 0, 1, 8'h00, 0);
        vecs[16] = mk(8'd4,   9'h1BF, 0, 5'd0,  8'h00, 9'h1BF, 1, 0, 1, 8'h00, 1);
        vecs[17] = mk(8'd4,   9'h0F0, 1, 5'd31, 8'h7E, 9'h1BF, 0, 0, 1, 8'h00, 1);
        vecs[18] = mk(8'd4,   9'h0F1, 0, 5'd0,  8'h00, 9'h1BF, 0, 0, 1, 8'h7E, 1);
        // after mid-run reset: FILL again, table cleared
        vecs[19] = mk(8'd0,   9'h1E0, 0, 5'd0,  8'h00, 9'h000, 0, 0, 0, 8'h00, 0);
        vecs[20] = mk(8'd1,   9'h000, 0, 5'd0,  8'h00, 9'h1E0, 1, 1, 1, 8'h00, 0);

        reset      = 1'b1;
        pc         = '0;
        imem_rdata = '0;
        lut_we     = 1'b0;
        lut_waddr  = '0;
        lut_wdata  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            if (i != 0) @(negedge clk);
            apply(i);
        end

        // Asynchronous reset from HALTED: outputs clear without a clock edge
        @(negedge clk);
        imem_rdata = 9'h155;
        lut_we     = 1'b0;
        reset      = 1'b1;
        #1;
        chk("async_halt",     100, 32'(halt),      32'd0);
        chk("async_ir",       100, 32'(ir),        32'd0);
        chk("async_ir_valid", 100, 32'(ir_valid),  32'd0);
        chk("async_table",    100, 32'(BranchOut), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        apply(19);
        @(negedge clk);
        apply(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
